// File: rtl/stack_unit_pkg.sv
// Shared definitions for the hardware stack: default word width, default depth
// and the decoded strobe operation used by the control logic.
package stack_unit_pkg;

   localparam int STACK_DATA_W = 16;
   localparam int STACK_DEPTH  = 16;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_SWAP = 2'b11
   } stack_op_e;

endpackage

// File: rtl/stack_unit_regfile.sv
// Stack storage: DEPTH x DATA_W registers with one synchronous write port and
// one asynchronous read port. Contents are deliberately never reset.
module stack_regfile
   import stack_unit_pkg::*;
#(
   parameter int DATA_W = STACK_DATA_W,
   parameter int DEPTH  = STACK_DEPTH
) (
   input  logic                       CLK,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]          rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware call/data stack: push/pop strobes, zero-latency top-of-stack read,
// sticky overflow/underflow flags. All control lives here; storage is stack_regfile.
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int DATA_W = STACK_DATA_W,
   parameter int DEPTH  = STACK_DEPTH
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       stack_read_data,
   input  logic                       stack_write_data,
   input  logic [DATA_W-1:0]          DATA_IN,
   output logic [DATA_W-1:0]          DATA_OUT,
   output logic                       DATA_OE,
   output logic [$clog2(DEPTH):0]     SP,
   output logic                       EMPTY,
   output logic                       FULL,
   output logic                       OVF,
   output logic                       UNF
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

   stack_op_e         op;
   logic [AW:0]       sp_nxt;
   logic              ovf_set;
   logic              unf_set;
   logic              pop_ok;
   logic              we;
   logic [AW-1:0]     waddr;
   logic [AW-1:0]     top_addr;
   logic [DATA_W-1:0] rdata;

   assign EMPTY    = (SP == '0);
   assign FULL     = (SP == SP_FULL);
   assign top_addr = AW'(SP - 1'b1);

   always_comb begin
      unique case ({stack_read_data, stack_write_data})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_SWAP;
         default: op = OP_IDLE;
      endcase
   end

   // A simultaneous push+pop on an empty stack is an underflow; the push is dropped.
   always_comb begin
      sp_nxt  = SP;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      pop_ok  = 1'b0;
      we      = 1'b0;
      waddr   = SP[AW-1:0];
      case (op)
         OP_PUSH: begin
            if (FULL) begin
               ovf_set = 1'b1;
            end else begin
               we     = 1'b1;
               sp_nxt = SP + 1'b1;
            end
         end
         OP_POP: begin
            if (EMPTY) begin
               unf_set = 1'b1;
            end else begin
               pop_ok = 1'b1;
               sp_nxt = SP - 1'b1;
            end
         end
         OP_SWAP: begin
            if (EMPTY) begin
               unf_set = 1'b1;
            end else begin
               pop_ok = 1'b1;
               we     = 1'b1;
               waddr  = top_addr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         SP  <= '0;
         OVF <= 1'b0;
         UNF <= 1'b0;
      end else begin
         SP  <= sp_nxt;
         OVF <= OVF | ovf_set;
         UNF <= UNF | unf_set;
      end
   end

   // Reset gates both the storage write and the output, so nothing moves while it is low.
   stack_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_regfile (
      .CLK   (CLK),
      .we    (we & RESET),
      .waddr (waddr),
      .wdata (DATA_IN),
      .raddr (top_addr),
      .rdata (rdata)
   );

   assign DATA_OE  = pop_ok & RESET;
   assign DATA_OUT = DATA_OE ? rdata : '0;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: vector table for the basic push/pop scenarios,
// hand-written sequences for fill/overflow and asynchronous reset.
module tb_stack_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        push;
   logic        pop;
   logic [15:0] din;
   logic [15:0] DATA_OUT;
   logic        DATA_OE;
   logic [4:0]  SP;
   logic        EMPTY, FULL, OVF, UNF;

   int n_checks = 0;
   int n_err    = 0;
   logic [15:0] ip = 16'h0000;
   logic [15:0] last_out;
   logic        last_oe;

   typedef struct {
      logic        push;
      logic        pop;
      logic [15:0] din;
      logic [15:0] exp_out;
      logic        exp_oe;
      logic [4:0]  exp_sp;
      logic        exp_ovf;
      logic        exp_unf;
   } vec_t;

   vec_t vq[$];

   stack_unit #(.DATA_W(16), .DEPTH(16)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .stack_read_data  (push),
      .stack_write_data (pop),
      .DATA_IN          (din),
      .DATA_OUT         (DATA_OUT),
      .DATA_OE          (DATA_OE),
      .SP               (SP),
      .EMPTY            (EMPTY),
      .FULL             (FULL),
      .OVF              (OVF),
      .UNF              (UNF)
   );

   always #5 CLK = ~CLK;

   // Emulated instruction pointer: RET loads it from the stack on the pop edge.
   always @(posedge CLK) begin
      if (DATA_OE === 1'b1) ip <= DATA_OUT;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic pu, input logic po, input logic [15:0] d,
                               input logic [15:0] eo, input logic eoe, input logic [4:0] esp,
                               input logic eovf, input logic eunf);
      vec_t v;
      v.push = pu; v.pop = po; v.din = d; v.exp_out = eo; v.exp_oe = eoe;
      v.exp_sp = esp; v.exp_ovf = eovf; v.exp_unf = eunf;
      return v;
   endfunction

   task automatic op(input logic pu, input logic po, input logic [15:0] d);
      @(negedge CLK);
      push = pu; pop = po; din = d;
      #1;
      last_out = DATA_OUT;
      last_oe  = DATA_OE;
      @(posedge CLK);
      #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      op(v.push, v.pop, v.din);
      check($sformatf("v%0d DATA_OUT", idx), 32'(last_out), 32'(v.exp_out));
      check($sformatf("v%0d DATA_OE", idx), 32'(last_oe), 32'(v.exp_oe));
      check($sformatf("v%0d SP", idx), 32'(SP), 32'(v.exp_sp));
      check($sformatf("v%0d EMPTY", idx), 32'(EMPTY), 32'(v.exp_sp == 5'd0));
      check($sformatf("v%0d FULL", idx), 32'(FULL), 32'(v.exp_sp == 5'd16));
      check($sformatf("v%0d OVF", idx), 32'(OVF), 32'(v.exp_ovf));
      check($sformatf("v%0d UNF", idx), 32'(UNF), 32'(v.exp_unf));
   endtask

   initial begin
      RESET = 1'b0; push = 1'b0; pop = 1'b0; din = 16'h0000;

      // Scenario A
      vq.push_back(mk(1, 0, 16'h0011, 16'h0000, 0, 5'd1, 0, 0));
      vq.push_back(mk(1, 0, 16'h0022, 16'h0000, 0, 5'd2, 0, 0));
      vq.push_back(mk(1, 0, 16'h0033, 16'h0000, 0, 5'd3, 0, 0));
      vq.push_back(mk(0, 1, 16'h0000, 16'h0033, 1, 5'd2, 0, 0));
      vq.push_back(mk(0, 1, 16'h0000, 16'h0022, 1, 5'd1, 0, 0));
      vq.push_back(mk(0, 1, 16'h0000, 16'h0011, 1, 5'd0, 0, 0));
      // Scenario C
      vq.push_back(mk(0, 1, 16'h0000, 16'h0000, 0, 5'd0, 0, 1));
      vq.push_back(mk(1, 0, 16'h0005, 16'h0000, 0, 5'd1, 0, 1));
      vq.push_back(mk(0, 1, 16'h0000, 16'h0005, 1, 5'd0, 0, 1));
      // Scenario D
      vq.push_back(mk(1, 0, 16'h0011, 16'h0000, 0, 5'd1, 0, 1));
      vq.push_back(mk(1, 0, 16'h00AA, 16'h0000, 0, 5'd2, 0, 1));
      vq.push_back(mk(1, 1, 16'h00BB, 16'h00AA, 1, 5'd2, 0, 1));
      vq.push_back(mk(0, 1, 16'h0000, 16'h00BB, 1, 5'd1, 0, 1));
      vq.push_back(mk(0, 1, 16'h0000, 16'h0011, 1, 5'd0, 0, 1));
      // Scenario E (CALL/RET)
      vq.push_back(mk(1, 0, 16'h0040, 16'h0000, 0, 5'd1, 0, 1));
      vq.push_back(mk(1, 0, 16'h1234, 16'h0000, 0, 5'd2, 0, 1));
      vq.push_back(mk(0, 1, 16'h0000, 16'h1234, 1, 5'd1, 0, 1));
      vq.push_back(mk(0, 1, 16'h0000, 16'h0040, 1, 5'd0, 0, 1));
      // idle, push+pop on empty (push dropped), idle
      vq.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 1));
      vq.push_back(mk(1, 1, 16'h5555, 16'h0000, 0, 5'd0, 0, 1));
      vq.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 1));

      #12;
      check("reset SP", 32'(SP), 32'd0);
      check("reset EMPTY", 32'(EMPTY), 32'd1);
      check("reset FULL", 32'(FULL), 32'd0);
      check("reset OVF", 32'(OVF), 32'd0);
      check("reset UNF", 32'(UNF), 32'd0);
      check("reset DATA_OE", 32'(DATA_OE), 32'd0);
      check("reset DATA_OUT", 32'(DATA_OUT), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         apply(vq[i], i);
      end
      check("RET ip", 32'(ip), 32'h0040);

      // Scenario B: fill, overflow, pop returns the 16th word
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("B reset UNF", 32'(UNF), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op(1'b1, 1'b0, 16'h1000 + 16'(i));
      end
      check("B SP full", 32'(SP), 32'd16);
      check("B FULL", 32'(FULL), 32'd1);
      check("B EMPTY", 32'(EMPTY), 32'd0);
      check("B OVF before", 32'(OVF), 32'd0);
      op(1'b1, 1'b0, 16'hBEEF);
      check("B OVF", 32'(OVF), 32'd1);
      check("B SP after ovf", 32'(SP), 32'd16);
      check("B FULL after ovf", 32'(FULL), 32'd1);
      op(1'b0, 1'b1, 16'h0000);
      check("B pop DATA_OUT", 32'(last_out), 32'h100F);
      check("B pop DATA_OE", 32'(last_oe), 32'd1);
      check("B SP after pop", 32'(SP), 32'd15);
      check("B OVF sticky", 32'(OVF), 32'd1);
      for (int i = 0; i < 10; i++) begin
         op(1'b0, 1'b1, 16'h0000);
      end
      check("pop to 5 DATA_OUT", 32'(last_out), 32'h1005);
      check("pop to 5 SP", 32'(SP), 32'd5);

      // Scenario F: asynchronous reset mid-cycle with a push strobe active
      @(negedge CLK);
      push = 1'b1; din = 16'h7777;
      #2;
      RESET = 1'b0;
      #1;
      check("F SP", 32'(SP), 32'd0);
      check("F OVF", 32'(OVF), 32'd0);
      check("F UNF", 32'(UNF), 32'd0);
      check("F EMPTY", 32'(EMPTY), 32'd1);
      pop = 1'b1;
      #1;
      check("F DATA_OE in reset", 32'(DATA_OE), 32'd0);
      check("F DATA_OUT in reset", 32'(DATA_OUT), 32'd0);
      @(posedge CLK);
      #1;
      check("F push lost", 32'(SP), 32'd0);
      @(negedge CLK);
      RESET = 1'b1; push = 1'b1; pop = 1'b0; din = 16'h0009;
      @(posedge CLK);
      #1;
      push = 1'b0;
      check("first edge after reset SP", 32'(SP), 32'd1);
      op(1'b0, 1'b1, 16'h0000);
      check("first edge after reset data", 32'(last_out), 32'h0009);
      check("first edge after reset SP end", 32'(SP), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The parameter list SHALL be: DATA_W, default 16, width of a stack word.
REQ-002 The parameter list SHALL also include: DEPTH, default 16, number of entries (power of two, at least 4).
REQ-003 The port list SHALL be, in order:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- stack_read_data  input  1  push strobe (PUSH, CALL, GET_Sx); stack captures DATA_IN.
- stack_write_data  input  1  pop strobe (POP, RET, SET_Sx); stack presents top on DATA_OUT.
- DATA_IN  input  DATA_W  word to push (register value or return IP).
- DATA_OUT  output  DATA_W  top-of-stack during pop, else 0.
- DATA_OE  output  1  high while DATA_OUT is valid (pop accepted).
- SP  output  log2(DEPTH)+1  current entry count.
- EMPTY  output  1  SP == 0.
- FULL  output  1  SP == DEPTH.
- OVF  output  1  sticky overflow flag.
- UNF  output  1  sticky underflow flag.

Function
REQ-004 Storage SHALL be DEPTH x DATA_W registers; entry SP-1 SHALL be the top of stack.
REQ-005 Push only (push=1, pop=0, not FULL) SHALL write DATA_IN to entry SP and increment SP on the same edge.
REQ-006 Pop only (pop=1, push=0, not EMPTY) SHALL drive entry SP-1 on DATA_OUT combinationally in the same cycle, assert DATA_OE, and decrement SP on the closing edge. This zero-latency read lets RET load IP in one cycle.
REQ-007 Push and pop in the same cycle with SP>0 SHALL drive the old top on DATA_OUT with DATA_OE=1, overwrite entry SP-1 with DATA_IN, and leave SP unchanged.
REQ-008 Push and pop in the same cycle with SP==0 SHALL be treated as a pop on empty (REQ-010), and the push SHALL be dropped.
REQ-009 Push while FULL (pop=0) SHALL leave the storage and SP unchanged and set OVF.
REQ-010 Pop while EMPTY SHALL drive DATA_OUT=0 with DATA_OE=0, leave SP unchanged, and set UNF.
REQ-011 OVF and UNF SHALL stay set until reset; there is no software clear.
REQ-012 With no strobe active, SP, the storage and the flags SHALL hold, and DATA_OUT SHALL be 0 with DATA_OE=0.
REQ-013 EMPTY and FULL SHALL be combinational decodes of the registered SP.
REQ-014 SP arithmetic SHALL use log2(DEPTH)+1 bits and SHALL never wrap; REQ-009 and REQ-010 are the guards.
REQ-015 Entries at index SP or above SHALL be unobservable on DATA_OUT.

Reset
REQ-016 RESET low SHALL immediately force SP=0, OVF=0 and UNF=0, giving EMPTY=1 and FULL=0.
REQ-017 RESET low SHALL force DATA_OUT=0 and DATA_OE=0 regardless of the strobes.
REQ-018 Storage contents SHALL NOT be cleared on reset.
REQ-019 Reset asserted mid-operation SHALL abandon any push or pop in that cycle.
REQ-020 The first edge after reset deassertion SHALL be accepted as a normal operation.

Structure
REQ-021 The shared include SHALL carry the data-width define and the default stack depth; the block SHALL define no local copies of either.
REQ-022 Storage SHALL be a sub-module stack_regfile: one synchronous write port, one asynchronous read port addressed by SP-1.
REQ-023 All control (SP, flags, output gating) SHALL reside in stack_unit.

Verification
REQ-024 Scenario A: after reset, push 0x0011, 0x0022, 0x0033, then pop three times -> DATA_OUT reads 0x0033, 0x0022, 0x0011, each with DATA_OE=1 in the pop cycle; SP ends at 0 and EMPTY=1.
REQ-025 Scenario B: push 16 words (DEPTH=16), then push 0xBEEF -> FULL=1, OVF=1, SP=16; the next pop returns the 16th word, not 0xBEEF.
REQ-026 Scenario C: pop on empty after reset -> DATA_OUT=0, DATA_OE=0, UNF=1, SP=0; a subsequent push 0x0005 then pop returns 0x0005.
REQ-027 Scenario D: SP=2 with top 0x00AA; push 0x00BB and pop in the same cycle -> DATA_OUT=0x00AA that cycle, SP stays 2; the next pop returns 0x00BB.
REQ-028 Scenario E: CALL/RET emulation: push IP=0x0040, push 0x1234, pop, pop -> the second pop returns 0x0040 combinationally, and IP loads it on that edge.
REQ-029 Scenario F: RESET pulsed low with SP=5 and a push strobe active -> SP=0, OVF=0 and UNF=0 immediately; the push is lost.
